// File: rtl/clock_pkg.sv
// Shared clock/alarm definitions: time moduli used by the counters and the
// alarm sequencer state encoding.
package clock_pkg;

    localparam int DEFAULT_NS = 60;
    localparam int DEFAULT_NH = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RING   = 2'd2,
        SNOOZE = 2'd3
    } alarm_state_t;

endpackage

// File: rtl/time_add.sv
// Combinational minute/hour modular adder: (hrs:min) + addend minutes, with
// the addend assumed smaller than one hour.
module time_add #(
    parameter int NS = 60,
    parameter int NH = 24
) (
    input  logic [6:0] min,
    input  logic [6:0] hrs,
    input  logic [6:0] addend,
    output logic [6:0] sum_min,
    output logic [6:0] sum_hrs
);

    logic [7:0] m;
    logic [7:0] h;
    logic       carry;

    always_comb begin
        m       = {1'b0, min} + {1'b0, addend};
        carry   = (m >= 8'(NS));
        sum_min = carry ? 7'(m - 8'(NS)) : m[6:0];
        h       = {1'b0, hrs} + {7'd0, carry};
        sum_hrs = (h == 8'(NH)) ? 7'd0 : h[6:0];
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm control: arms on alarmon, rings once per matching minute for a bounded
// period, supports a limited number of snoozes with wrap-around target time.
module alarm_sequencer import clock_pkg::*; #(
    parameter int NS         = DEFAULT_NS,
    parameter int NH         = DEFAULT_NH,
    parameter int SNOOZE_MIN = 9,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3,
    localparam int SW        = $clog2(MAX_SNOOZE + 1),
    localparam int RW        = (RING_SEC > 1) ? $clog2(RING_SEC) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [6:0]    tsec,
    input  logic [6:0]    tmin,
    input  logic [6:0]    thrs,
    input  logic [6:0]    amin,
    input  logic [6:0]    ahrs,
    input  logic          alarmon,
    input  logic          snooze,
    output logic          buzz,
    output logic          snoozing,
    output logic [SW-1:0] snooze_ct,
    output alarm_state_t  dbg_state
);

    alarm_state_t  state;
    alarm_state_t  state_nx;
    logic [RW-1:0] ring_ct;
    logic [6:0]    tgt_min;
    logic [6:0]    tgt_hrs;
    logic [6:0]    add_min;
    logic [6:0]    add_hrs;
    logic [6:0]    cmp_min;
    logic [6:0]    cmp_hrs;
    logic          snooze_q;
    logic          snooze_edge;
    logic          match;
    logic          snooze_take;
    logic          ring_done;

    time_add #(.NS(NS), .NH(NH)) u_time_add (
        .min     (tmin),
        .hrs     (thrs),
        .addend  (7'(SNOOZE_MIN)),
        .sum_min (add_min),
        .sum_hrs (add_hrs)
    );

    // Live alarm setting while armed so edits apply at once; held target while snoozing.
    assign cmp_min     = (state == SNOOZE) ? tgt_min : amin;
    assign cmp_hrs     = (state == SNOOZE) ? tgt_hrs : ahrs;
    assign match       = tick && (tsec == 7'd0) && (tmin == cmp_min) && (thrs == cmp_hrs);
    assign snooze_edge = snooze & ~snooze_q;
    assign snooze_take = (state == RING) && snooze_edge && (snooze_ct < SW'(MAX_SNOOZE));
    assign ring_done   = (state == RING) && tick && (ring_ct == RW'(RING_SEC - 1));

    always_comb begin
        state_nx = state;
        if (!alarmon) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = ARMED;
                ARMED:   if (match) state_nx = RING;
                RING: begin
                    if (snooze_take)    state_nx = SNOOZE;
                    else if (ring_done) state_nx = ARMED;
                end
                SNOOZE:  if (match) state_nx = RING;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snooze_q  <= 1'b0;
            ring_ct   <= '0;
            snooze_ct <= '0;
            tgt_min   <= 7'd0;
            tgt_hrs   <= 7'd0;
        end else begin
            snooze_q <= snooze;
            if (!alarmon) begin
                ring_ct   <= '0;
                snooze_ct <= '0;
                tgt_min   <= 7'd0;
                tgt_hrs   <= 7'd0;
            end else if ((state == ARMED || state == SNOOZE) && match) begin
                ring_ct <= '0;
            end else if (snooze_take) begin
                tgt_min   <= add_min;
                tgt_hrs   <= add_hrs;
                snooze_ct <= snooze_ct + 1'b1;
            end else if (ring_done) begin
                ring_ct   <= '0;
                snooze_ct <= '0;
            end else if (state == RING && tick) begin
                ring_ct <= ring_ct + 1'b1;
            end
        end
    end

    assign buzz      = (state == RING);
    assign snoozing  = (state == SNOOZE);
    assign dbg_state = state;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: a minute-of-day reference model checked every
// cycle, a snooze wrap-around vector table, directed corner sequences and random traffic.
module tb_alarm_sequencer;
    import clock_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick = 1'b0;
    logic         alarmon = 1'b0;
    logic         snooze = 1'b0;
    logic [6:0]   tsec = 7'd0;
    logic [6:0]   tmin = 7'd0;
    logic [6:0]   thrs = 7'd0;
    logic [6:0]   amin = 7'd0;
    logic [6:0]   ahrs = 7'd0;
    logic         buzz;
    logic         snoozing;
    logic [1:0]   snooze_ct;
    alarm_state_t dbg_state;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 off, 1 armed, 2 ringing, 3 snoozing; times in minutes of day.
    int m_mode   = 0;
    int m_rung   = 0;
    int m_used   = 0;
    int m_target = 0;
    bit m_prev   = 1'b0;
    int now_s    = 0;

    typedef struct {
        int th;
        int tm;
        int eh;
        int em;
    } wrap_vec_t;
    wrap_vec_t vecs[6];

    alarm_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .tsec      (tsec),
        .tmin      (tmin),
        .thrs      (thrs),
        .amin      (amin),
        .ahrs      (ahrs),
        .alarmon   (alarmon),
        .snooze    (snooze),
        .buzz      (buzz),
        .snoozing  (snoozing),
        .snooze_ct (snooze_ct),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_rung = 0;
        m_used = 0;
        m_prev = 1'b0;
    endtask

    task automatic model_step();
        bit edge_s;
        int nowm;
        int am;
        edge_s = snooze && !m_prev;
        m_prev = snooze;
        nowm   = int'(thrs) * 60 + int'(tmin);
        am     = int'(ahrs) * 60 + int'(amin);
        if (!alarmon) begin
            m_mode = 0;
            m_rung = 0;
            m_used = 0;
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1: if (tick && tsec == 0 && nowm == am) begin
                    m_mode = 2;
                    m_rung = 0;
                end
                2: if (edge_s && m_used < 3) begin
                    m_mode   = 3;
                    m_used   = m_used + 1;
                    m_target = (nowm + 9) % 1440;
                end else if (tick) begin
                    m_rung = m_rung + 1;
                    if (m_rung == 60) begin
                        m_mode = 1;
                        m_used = 0;
                    end
                end
                default: if (tick && tsec == 0 && nowm == m_target) begin
                    m_mode = 2;
                    m_rung = 0;
                end
            endcase
        end
    endtask

    // Inputs are changed only around the falling edge; outputs sampled 1ns after the rising edge.
    task automatic clk_cycle();
        model_step();
        @(posedge clk);
        #1;
        tests++;
        if (buzz !== (m_mode == 2) || snoozing !== (m_mode == 3) || snooze_ct !== 2'(m_used)) begin
            fails++;
            $display("FAIL model_cycle: got buzz=%b snoozing=%b ct=%0d required buzz=%0d snoozing=%0d ct=%0d (t=%0t)",
                     buzz, snoozing, snooze_ct, m_mode == 2, m_mode == 3, m_used, $time);
        end
        @(negedge clk);
    endtask

    task automatic set_time(input int s);
        thrs = 7'(s / 3600);
        tmin = 7'((s / 60) % 60);
        tsec = 7'(s % 60);
    endtask

    task automatic set_alarm(input int h, input int m);
        ahrs = 7'(h);
        amin = 7'(m);
    endtask

    task automatic second_tick();
        set_time(now_s);
        tick = 1'b1;
        clk_cycle();
        tick = 1'b0;
        clk_cycle();
        now_s = (now_s + 1) % 86400;
    endtask

    task automatic run_secs(input int n);
        for (int i = 0; i < n; i++) second_tick();
    endtask

    task automatic press_snooze();
        snooze = 1'b1;
        clk_cycle();
        snooze = 1'b0;
        clk_cycle();
    endtask

    task automatic hard_reset();
        rst    = 1'b0;
        tick   = 1'b0;
        snooze = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic start_ring(input int h, input int m);
        hard_reset();
        set_alarm(h, m);
        alarmon = 1'b1;
        clk_cycle();
        now_s = (h * 3600 + m * 60 - 1 + 86400) % 86400;
        run_secs(2);
    endtask

    initial begin
        int n;
        int tgt;

        vecs[0] = '{th: 23, tm: 55, eh: 0,  em: 4};
        vecs[1] = '{th: 12, tm: 59, eh: 13, em: 8};
        vecs[2] = '{th: 7,  tm: 30, eh: 7,  em: 39};
        vecs[3] = '{th: 23, tm: 51, eh: 0,  em: 0};
        vecs[4] = '{th: 10, tm: 50, eh: 10, em: 59};
        vecs[5] = '{th: 23, tm: 59, eh: 0,  em: 8};

        // Reset state
        rst = 1'b0;
        alarmon = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_buzz", buzz, 0);
        check("reset_snoozing", snoozing, 0);
        check("reset_ct", snooze_ct, 0);
        check("reset_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Basic ring at 07:30, exact length, no retrigger within the minute
        set_alarm(7, 30);
        clk_cycle();
        now_s = 7 * 3600 + 29 * 60 + 58;
        run_secs(2);
        check("pre_match", buzz, 0);
        set_time(now_s);
        tick = 1'b1;
        clk_cycle();
        check("buzz_rise", buzz, 1);
        tick = 1'b0;
        clk_cycle();
        now_s++;
        n = 0;
        while (buzz && n < 100) begin
            second_tick();
            n++;
        end
        check("ring_len", n, 60);
        run_secs(30);
        check("no_retrigger", buzz, 0);

        // Snooze wrap-around vectors
        for (int v = 0; v < 6; v++) begin
            start_ring(vecs[v].th, vecs[v].tm);
            check("wrap_ring", buzz, 1);
            run_secs(3);
            press_snooze();
            check("wrap_snoozing", snoozing, 1);
            check("wrap_buzz_off", buzz, 0);
            check("wrap_ct", snooze_ct, 1);
            tgt = vecs[v].eh * 3600 + vecs[v].em * 60;
            now_s = (tgt - 60 + 86400) % 86400;
            run_secs(1);
            check("wrap_early", buzz, 0);
            now_s = (tgt - 1 + 86400) % 86400;
            run_secs(2);
            check("wrap_fire", buzz, 1);
        end

        // Snooze limit: three accepted, fourth ignored, timeout clears the count
        start_ring(6, 0);
        for (int k = 1; k <= 3; k++) begin
            press_snooze();
            check("max_ct", snooze_ct, k);
            check("max_snoozing", snoozing, 1);
            now_s = (m_target * 60 - 1 + 86400) % 86400;
            run_secs(2);
            check("max_refire", buzz, 1);
        end
        press_snooze();
        check("fourth_ct", snooze_ct, 3);
        check("fourth_buzz", buzz, 1);
        n = 0;
        while (buzz && n < 100) begin
            second_tick();
            n++;
        end
        check("max_timeout_len", n, 60);
        check("max_ct_cleared", snooze_ct, 0);

        // alarmon dropped while ringing
        start_ring(6, 0);
        run_secs(2);
        alarmon = 1'b0;
        clk_cycle();
        check("off_ring_buzz", buzz, 0);
        check("off_ring_state", dbg_state, IDLE);
        alarmon = 1'b1;
        clk_cycle();

        // alarmon dropped while snoozing; the old target must not fire
        start_ring(6, 0);
        press_snooze();
        alarmon = 1'b0;
        clk_cycle();
        check("off_snz_snoozing", snoozing, 0);
        check("off_snz_ct", snooze_ct, 0);
        check("off_snz_state", dbg_state, IDLE);
        alarmon = 1'b1;
        clk_cycle();
        now_s = 6 * 3600 + 9 * 60 - 1;
        run_secs(2);
        check("stale_target", buzz, 0);

        // Asynchronous reset mid-ring, then a normal ring the next day
        start_ring(7, 30);
        press_snooze();
        now_s = (m_target * 60 - 1 + 86400) % 86400;
        run_secs(4);
        check("pre_rst_ct", snooze_ct, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_buzz", buzz, 0);
        check("async_snoozing", snoozing, 0);
        check("async_ct", snooze_ct, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        clk_cycle();
        now_s = 7 * 3600 + 29 * 60 + 58;
        run_secs(2);
        check("post_rst_quiet", buzz, 0);
        run_secs(1);
        check("post_rst_ring", buzz, 1);

        // Snooze edge coincides with the timeout tick
        start_ring(8, 0);
        run_secs(59);
        check("pre_coincide", buzz, 1);
        snooze = 1'b1;
        set_time(now_s);
        tick = 1'b1;
        clk_cycle();
        check("coincide_snoozing", snoozing, 1);
        check("coincide_ct", snooze_ct, 1);
        tick = 1'b0;
        snooze = 1'b0;
        clk_cycle();
        now_s++;

        // Random traffic against the model
        hard_reset();
        set_alarm($urandom_range(0, 23), $urandom_range(0, 59));
        alarmon = 1'b1;
        now_s = $urandom_range(0, 86399);
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                second_tick();
            end else if (r < 80) begin
                snooze = ~snooze;
                clk_cycle();
            end else if (r < 82) begin
                alarmon = ~alarmon;
                clk_cycle();
            end else if (r < 88) begin
                now_s = ((int'(ahrs) * 60 + int'(amin)) * 60 - $urandom_range(1, 3) + 86400) % 86400;
                second_tick();
            end else if (r < 94) begin
                if (m_mode == 3)
                    now_s = (m_target * 60 - $urandom_range(1, 3) + 86400) % 86400;
                else
                    now_s = $urandom_range(0, 86399);
                second_tick();
            end else if (r < 96) begin
                set_alarm($urandom_range(0, 23), $urandom_range(0, 59));
                clk_cycle();
            end else begin
                clk_cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
